// File: rtl/timer_cmp.sv
// rtl/timer_cmp.sv - prescaled free-running counter with NCH compare channels, W1C status and level irqs
// Optional TIMER_SNAPSHOT_EN: a CNT_LO read latches the upper counter half so CNT_HI reads are atomic.
module timer_cmp #(
  parameter int NCH      = 2,
  parameter int PRESCALE = 100,
  parameter int CNTW     = 64
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           sel,
  input  logic           we,
  input  logic [31:0]    addr,
  input  logic [31:0]    din,
  output logic [31:0]    dout,
  output logic [NCH-1:0] irq
);

  localparam int HIW = CNTW - 32;
  localparam int PW  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  localparam logic [3:0] IDX_CNT_LO = 4'd0;
  localparam logic [3:0] IDX_CNT_HI = 4'd1;
  localparam logic [3:0] IDX_CTRL   = 4'd2;
  localparam logic [3:0] IDX_STATUS = 4'd3;

  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic            en_q, en_d;
  logic [NCH-1:0]  ien_q, ien_d;
  logic [NCH-1:0]  status_q, status_d;
  logic [CNTW-1:0] cmp_q [NCH];
  logic [CNTW-1:0] cmp_d [NCH];
  logic [31:0]     dout_q, dout_d;

  logic [3:0]      idx;
  logic            rd, wr;
  logic            tick, cnt_upd;
  logic [NCH-1:0]  hit_cmp_lo, hit_cmp_hi;
  logic [HIW-1:0]  cnt_hi_rd;
  logic [31:0]     rdata;
  logic            unused_addr;

  assign idx         = addr[5:2];
  assign rd          = sel & ~we;
  assign wr          = sel & we;
  assign unused_addr = ^{addr[31:6], addr[1:0]};

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      hit_cmp_lo[i] = (idx == 4'(4 + 2 * i));
      hit_cmp_hi[i] = (idx == 4'(5 + 2 * i));
    end
  end

`ifdef TIMER_SNAPSHOT_EN
  logic [HIW-1:0] snap_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      snap_q <= '0;
    end else if (rd && idx == IDX_CNT_LO) begin
      snap_q <= cnt_q[CNTW-1:32];
    end
  end

  assign cnt_hi_rd = snap_q;
`else
  assign cnt_hi_rd = cnt_q[CNTW-1:32];
`endif

  // Software writes to the counter override the tick; a CTRL clear overrides both.
  always_comb begin
    tick    = en_q && (pre_q == PRE_LAST);
    pre_d   = pre_q;
    cnt_d   = cnt_q;
    cnt_upd = 1'b0;
    if (en_q) begin
      pre_d = tick ? '0 : pre_q + 1'b1;
    end
    if (tick) begin
      cnt_d   = cnt_q + 1'b1;
      cnt_upd = 1'b1;
    end
    if (wr && idx == IDX_CNT_LO) begin
      cnt_d   = {cnt_q[CNTW-1:32], din};
      pre_d   = '0;
      cnt_upd = 1'b1;
    end
    if (wr && idx == IDX_CNT_HI) begin
      cnt_d   = {din[HIW-1:0], cnt_q[31:0]};
      pre_d   = '0;
      cnt_upd = 1'b1;
    end
    if (wr && idx == IDX_CTRL && din[1]) begin
      cnt_d   = '0;
      pre_d   = '0;
      cnt_upd = 1'b1;
    end
  end

  // Matches use the compare value held before any same-cycle CMP write; set beats W1C.
  always_comb begin
    en_d     = en_q;
    ien_d    = ien_q;
    status_d = status_q;
    if (wr && idx == IDX_CTRL) begin
      en_d  = din[0];
      ien_d = din[8 +: NCH];
    end
    if (wr && idx == IDX_STATUS) begin
      status_d = status_q & ~din[NCH-1:0];
    end
    for (int i = 0; i < NCH; i++) begin
      cmp_d[i] = cmp_q[i];
      if (wr && hit_cmp_lo[i]) begin
        cmp_d[i][31:0] = din;
      end
      if (wr && hit_cmp_hi[i]) begin
        cmp_d[i][CNTW-1:32] = din[HIW-1:0];
      end
      if (cnt_upd && cnt_d == cmp_q[i]) begin
        status_d[i] = 1'b1;
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (idx)
      IDX_CNT_LO: rdata = cnt_q[31:0];
      IDX_CNT_HI: rdata = 32'(cnt_hi_rd);
      IDX_CTRL: begin
        rdata[0]       = en_q;
        rdata[8 +: NCH] = ien_q;
      end
      IDX_STATUS: rdata[NCH-1:0] = status_q;
      default: begin
        for (int i = 0; i < NCH; i++) begin
          if (hit_cmp_lo[i]) begin
            rdata = cmp_q[i][31:0];
          end
          if (hit_cmp_hi[i]) begin
            rdata = 32'(cmp_q[i][CNTW-1:32]);
          end
        end
      end
    endcase
    dout_d = rd ? rdata : dout_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q    <= '0;
      pre_q    <= '0;
      en_q     <= 1'b0;
      ien_q    <= '0;
      status_q <= '0;
      dout_q   <= '0;
      for (int i = 0; i < NCH; i++) begin
        cmp_q[i] <= '1;
      end
    end else begin
      cnt_q    <= cnt_d;
      pre_q    <= pre_d;
      en_q     <= en_d;
      ien_q    <= ien_d;
      status_q <= status_d;
      dout_q   <= dout_d;
      for (int i = 0; i < NCH; i++) begin
        cmp_q[i] <= cmp_d[i];
      end
    end
  end

  assign dout = dout_q;
  assign irq  = status_q & ien_q;

endmodule

// File: tb/tb_timer_cmp.sv
// tb/tb_timer_cmp.sv - three timer_cmp configurations on one shared bus, checked every cycle against a model
// Directed scenarios pin literal values; a randomized phase exercises all registers and mid-run resets.
module tb_timer_cmp;

  localparam int NK = 3;
  localparam int CP [NK] = '{4, 1, 3};
  localparam int CN [NK] = '{2, 2, 3};
  localparam int CW [NK] = '{64, 64, 40};

  logic        clock;
  logic        reset;
  logic        sel;
  logic        we;
  logic [31:0] addr;
  logic [31:0] din;
  logic [31:0] dout0, dout1, dout2;
  logic [1:0]  irq0, irq1;
  logic [2:0]  irq2;

  timer_cmp #(.NCH(2), .PRESCALE(4), .CNTW(64)) u_dut0 (
    .clock(clock), .reset(reset), .sel(sel), .we(we), .addr(addr), .din(din),
    .dout(dout0), .irq(irq0)
  );
  timer_cmp #(.NCH(2), .PRESCALE(1), .CNTW(64)) u_dut1 (
    .clock(clock), .reset(reset), .sel(sel), .we(we), .addr(addr), .din(din),
    .dout(dout1), .irq(irq1)
  );
  timer_cmp #(.NCH(3), .PRESCALE(3), .CNTW(40)) u_dut2 (
    .clock(clock), .reset(reset), .sel(sel), .we(we), .addr(addr), .din(din),
    .dout(dout2), .irq(irq2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural model: one set of architectural registers per configuration.
  longint unsigned mc    [NK];
  int              mpre  [NK];
  logic            men   [NK];
  logic [3:0]      mien  [NK];
  logic [3:0]      mst   [NK];
  longint unsigned mcmp  [NK][4];
  logic [31:0]     mdout [NK];
  longint unsigned msnap [NK];

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  function automatic longint unsigned wmask(input int w);
    if (w == 64) return 64'hFFFF_FFFF_FFFF_FFFF;
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic logic [31:0] read_val(input int k, input int id);
    longint unsigned c;
    if (id == 0) return 32'(mc[k]);
`ifdef TIMER_SNAPSHOT_EN
    if (id == 1) return 32'(msnap[k]);
`else
    if (id == 1) return 32'(mc[k] >> 32);
`endif
    if (id == 2) return {20'h0, mien[k], 7'h0, men[k]};
    if (id == 3) return {28'h0, mst[k]};
    if (id >= 4 && id < 4 + 2 * CN[k]) begin
      c = mcmp[k][(id - 4) / 2];
      return (id % 2 == 0) ? 32'(c) : 32'(c >> 32);
    end
    return 32'h0;
  endfunction

  task automatic model_step(input int k);
    longint unsigned msk, nc, c;
    int np, id, ci;
    bit upd;
    logic [3:0] nmask;
    msk   = wmask(CW[k]);
    nmask = 4'((1 << CN[k]) - 1);
    if (reset) begin
      mc[k] = 0; mpre[k] = 0; men[k] = 1'b0; mien[k] = 4'h0; mst[k] = 4'h0;
      mdout[k] = 32'h0; msnap[k] = 0;
      for (int i = 0; i < 4; i++) mcmp[k][i] = msk;
      return;
    end
    id = int'(addr[5:2]);
    if (sel && !we) begin
      mdout[k] = read_val(k, id);
      if (id == 0) msnap[k] = mc[k] >> 32;
    end
    nc = mc[k]; np = mpre[k]; upd = 1'b0;
    if (men[k]) begin
      if (mpre[k] == CP[k] - 1) begin np = 0; nc = (mc[k] + 1) & msk; upd = 1'b1; end
      else np = mpre[k] + 1;
    end
    if (sel && we) begin
      if (id == 0) begin
        nc = (mc[k] & 64'hFFFF_FFFF_0000_0000) | {32'h0, din}; np = 0; upd = 1'b1;
      end else if (id == 1) begin
        nc = ({din, 32'h0} | (mc[k] & 64'hFFFF_FFFF)) & msk; np = 0; upd = 1'b1;
      end else if (id == 2 && din[1]) begin
        nc = 0; np = 0; upd = 1'b1;
      end
      if (id == 3) mst[k] = mst[k] & ~din[3:0] & nmask;
    end
    for (int i = 0; i < CN[k]; i++) if (upd && nc == mcmp[k][i]) mst[k][i] = 1'b1;
    if (sel && we) begin
      if (id == 2) begin men[k] = din[0]; mien[k] = din[11:8] & nmask; end
      if (id >= 4 && id < 4 + 2 * CN[k]) begin
        ci = (id - 4) / 2;
        c  = mcmp[k][ci];
        if (id % 2 == 0) c = (c & 64'hFFFF_FFFF_0000_0000) | {32'h0, din};
        else c = ({din, 32'h0} | (c & 64'hFFFF_FFFF)) & msk;
        mcmp[k][ci] = c;
      end
    end
    mc[k] = nc; mpre[k] = np;
  endtask

  always @(posedge clock) begin
    for (int k = 0; k < NK; k++) model_step(k);
  end

  function automatic logic [31:0] dut_dout(input int k);
    case (k)
      0: return dout0;
      1: return dout1;
      default: return dout2;
    endcase
  endfunction

  function automatic logic [3:0] dut_irq(input int k);
    case (k)
      0: return {2'b00, irq0};
      1: return {2'b00, irq1};
      default: return {1'b0, irq2};
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < NK; k++) begin
      check($sformatf("dout%0d", k), {32'h0, dut_dout(k)}, {32'h0, mdout[k]});
      check($sformatf("irq%0d", k), {60'h0, dut_irq(k)}, {60'h0, mst[k] & mien[k]});
    end
  endtask

  task automatic step();
    @(negedge clock);
    if (chk_on) compare_all();
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic bus_write(input int id, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = 32'(id * 4); din = d;
    step();
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input int id);
    sel = 1'b1; we = 1'b0; addr = 32'(id * 4); din = 32'h0;
    step();
    sel = 1'b0;
  endtask

  function automatic logic [31:0] rand_din(input int id);
    logic [31:0] d;
    d = $urandom;
    case (id)
      0: d = $urandom_range(0, 30);
      1: d = ($urandom_range(0, 7) == 0) ? $urandom : 32'h0;
      2: d = {20'h0, 4'($urandom_range(0, 15)), 6'h0,
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) != 0)};
      default: begin
        if (id >= 4 && id % 2 == 0) d = $urandom_range(0, 60);
        else if (id >= 5 && $urandom_range(0, 7) != 0) d = 32'h0;
      end
    endcase
    return d;
  endfunction

  int n;
  int id;
  logic [31:0] exp_hi;

  initial begin
    reset = 1'b1; sel = 1'b0; we = 1'b0; addr = 32'h0; din = 32'h0;
    step();
    chk_on = 1'b1;
    tick_n(2);
    reset = 1'b0;

    // Reset state
    for (int k = 0; k < NK; k++) check($sformatf("rst_dout%0d", k), {32'h0, dut_dout(k)}, 64'h0);
    bus_read(2);  check("rst_ctrl", {32'h0, dout0}, 64'h0);
    bus_read(3);  check("rst_status", {32'h0, dout0}, 64'h0);
    bus_read(4);  check("rst_cmp0_lo", {32'h0, dout0}, 64'hFFFF_FFFF);
    bus_read(5);  check("rst_cmp0_hi_w40", {32'h0, dout2}, 64'hFF);
    bus_read(0);  check("rst_cnt_lo", {32'h0, dout1}, 64'h0);

    // Tick rate over 40 enabled cycles
    bus_write(2, 32'h1);
    tick_n(40);
    bus_read(0);
    check("rate_p4", {32'h0, dout0}, 64'd10);
    check("rate_p1", {32'h0, dout1}, 64'd40);
    check("rate_p3", {32'h0, dout2}, 64'd13);

    // Wrap from all-ones
    bus_write(2, 32'h0);
    bus_write(1, 32'hFFFF_FFFF);
    bus_write(0, 32'hFFFF_FFFF);
    bus_read(3);  check("load_match_status", {32'h0, dout1}, 64'h3);
    bus_write(3, 32'hF);
    bus_write(2, 32'h1);
    bus_write(2, 32'h0);
    bus_read(0);  check("wrap_lo", {32'h0, dout1}, 64'h0);
                  check("wrap_p4_still_max", {32'h0, dout0}, 64'hFFFF_FFFF);
    bus_read(1);  check("wrap_hi", {32'h0, dout1}, 64'h0);
    bus_read(3);  check("wrap_status", {32'h0, dout1}, 64'h0);

    // Compare on channel 1 raises irq[1] when the counter reaches 5
    bus_write(2, 32'h2);
    bus_write(3, 32'hF);
    bus_write(6, 32'd5);
    bus_write(7, 32'h0);
    bus_write(2, 32'h201);
    n = 0;
    while (irq1[1] !== 1'b1 && n < 20) begin step(); n++; end
    check("irq1_rise_cycle", 64'(n), 64'd5);
    bus_write(3, 32'h2);
    check("irq1_w1c_drop", {63'h0, irq1[1]}, 64'h0);
    tick_n(5);
    check("irq1_no_retrigger", {63'h0, irq1[1]}, 64'h0);

    // W1C in the same cycle as a match: set wins
    bus_write(2, 32'h2);
    bus_write(3, 32'hF);
    bus_write(4, 32'd3);
    bus_write(5, 32'h0);
    bus_write(2, 32'h1);
    tick_n(2);
    bus_write(3, 32'h1);
    bus_read(3);  check("set_wins", {32'h0, dout1}, 64'h1);

    // Atomic 64-bit read across the 32-bit carry
    bus_write(1, 32'h1);
    bus_write(0, 32'hFFFF_FFFF);
    bus_read(0);  check("snap_lo", {32'h0, dout1}, 64'hFFFF_FFFF);
    bus_read(1);
`ifdef TIMER_SNAPSHOT_EN
    exp_hi = 32'h1;
`else
    exp_hi = 32'h2;
`endif
    check("snap_hi", {32'h0, dout1}, {32'h0, exp_hi});

    // Reset mid-count, with a bus write that reset must override
    bus_write(2, 32'h301);
    bus_write(1, 32'h0);
    bus_write(0, 32'h1234);
    reset = 1'b1; sel = 1'b1; we = 1'b1; addr = 32'h0; din = 32'h55;
    step();
    reset = 1'b0; sel = 1'b0; we = 1'b0;
    for (int k = 0; k < NK; k++) begin
      check($sformatf("midrst_dout%0d", k), {32'h0, dut_dout(k)}, 64'h0);
      check($sformatf("midrst_irq%0d", k), {60'h0, dut_irq(k)}, 64'h0);
    end
    bus_read(2);  check("midrst_ctrl", {32'h0, dout0}, 64'h0);
    bus_read(0);  check("midrst_cnt", {32'h0, dout1}, 64'h0);

    // Randomized traffic, including unmapped indices and occasional resets
    for (int c = 0; c < 4000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      sel   = ($urandom_range(0, 99) < 50);
      we    = 1'($urandom_range(0, 1));
      id    = $urandom_range(0, 15);
      addr  = $urandom;
      addr[5:2] = 4'(id);
      din   = rand_din(id);
      step();
    end
    reset = 1'b0; sel = 1'b0; we = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_cmp.md
TIMER_CMP -- requirements
Module: timer_cmp

Interface
REQ-001 SHALL provide parameter NCH, default 2, number of compare channels (1..4).
REQ-002 SHALL provide parameter PRESCALE, default 100, clock cycles per counter tick (>=1).
REQ-003 SHALL provide parameter CNTW, default 64, counter width in bits (33..64).
REQ-004 SHALL have port clock  input  1  clock for all state.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port sel  input  1  bus access strobe, one access per asserted cycle.
REQ-007 SHALL have port we  input  1  write when high, read when low (qualified by sel).
REQ-008 SHALL have port addr  input  32  byte address; only addr[5:2] decoded.
REQ-009 SHALL have port din  input  32  write data.
REQ-010 SHALL have port dout  output  32  registered read data.
REQ-011 SHALL have port irq  output  NCH  per-channel interrupt, level.

Function
REQ-012 SHALL decode word index addr[5:2]: 0 CNT_LO, 1 CNT_HI, 2 CTRL, 3 STATUS, 4+2i CMP_LO[i], 5+2i CMP_HI[i] for i<NCH; other indices unmapped.
REQ-013 SHALL define CTRL: bit0 EN, bit1 CLR (write-1 action, reads 0), bits[8+i] IEN[i]; other bits read 0.
REQ-014 SHALL, while EN=1, count prescaler 0..PRESCALE-1 and on terminal count wrap it to 0 and increment counter by 1 in the same cycle.
REQ-015 SHALL wrap counter from 2^CNTW-1 to 0 with no flag; prescaler SHALL hold value while EN=0.
REQ-016 SHALL set STATUS bit i in the cycle the counter is updated to a value equal to CMP[i] (increment or software load); no re-trigger while counter is static.
REQ-017 SHALL drive irq[i] = STATUS[i] & IEN[i], combinationally from registers.
REQ-018 SHALL clear STATUS bits written with 1 (W1C); if a match sets the same bit in that cycle, set wins.
REQ-019 SHALL, on write to CNT_LO/CNT_HI, load the addressed counter half, zero the prescaler, and suppress that cycle's increment.
REQ-020 SHALL, on CTRL write with CLR=1, zero counter and prescaler (EN/IEN take din values); clear beats increment.
REQ-021 SHALL register dout one cycle after sel&!we; dout SHALL hold its value otherwise and on writes.
REQ-022 SHALL return 0 for unmapped indices and for counter/compare bits at or above CNTW.
REQ-023 SHALL ignore writes to unmapped indices with no side effects.

Reset
REQ-024 SHALL on reset set counter 0, prescaler 0, CTRL 0, STATUS 0, all CMP to all-ones, dout 0, snapshot register 0.
REQ-025 SHALL let reset override any simultaneous bus access or tick.

Configuration
REQ-026 SHALL compile atomic 64-bit reads only when macro TIMER_SNAPSHOT_EN is defined.
REQ-027 SHALL, with TIMER_SNAPSHOT_EN, latch counter[CNTW-1:32] into a snapshot register on every CNT_LO read and return the snapshot on CNT_HI reads.
REQ-028 SHALL, without TIMER_SNAPSHOT_EN, return live counter[CNTW-1:32] on CNT_HI reads and contain no snapshot register.

Verification
REQ-029 SHALL verify tick rate: PRESCALE=4, EN=1 for 40 cycles after reset -> CNT_LO reads 10 (+/-1 per read latency).
REQ-030 SHALL verify wrap: CNTW=64, load CNT_HI=0xFFFFFFFF, CNT_LO=0xFFFFFFFF, EN=1, PRESCALE=1 -> next tick counter reads 0, no STATUS bit set (CMP reset all-ones only matched at load).
REQ-031 SHALL verify compare: CMP[1]=5, IEN[1]=1, EN=1 -> irq[1] rises the cycle counter becomes 5; W1C STATUS=0x2 drops irq[1]; counter 6 does not re-raise.
REQ-032 SHALL verify set-wins: W1C STATUS bit0 in the exact cycle counter reaches CMP[0] -> STATUS bit0 remains 1.
REQ-033 SHALL verify snapshot: counter=0x00000001_FFFFFFFF, PRESCALE=1, read LO then HI -> with macro HI=0x1; without macro HI=0x2.
REQ-034 SHALL verify reset mid-count: assert reset with EN=1, counter=0x1234 -> next cycle counter 0, CTRL 0, dout 0, irq 0.
